// File: rtl/key_expansion_seq_pkg.sv
// Shared constants, bus payloads and AES byte helpers for the iterative key-schedule engine.
package key_expansion_seq_pkg;

  localparam int unsigned NB        = 4;
  localparam int unsigned NK_MAX    = 8;
  localparam int unsigned W_DEPTH   = NB * (14 + 1);
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned KEY_W     = WORD_W * NK_MAX;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned ROUND_W   = 4;
  localparam int unsigned RK_W      = NB * WORD_W;
  localparam int unsigned ROUND_MAX = 14;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    MODE_128 = 2'd0,
    MODE_192 = 2'd1,
    MODE_256 = 2'd2,
    MODE_ILL = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_e;

  // Per-job key geometry derived from the mode input
  typedef struct packed {
    logic [3:0] nk;
    logic [3:0] nr;
  } key_cfg_t;

  // Single-word write into the schedule store
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_req_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // GF(2^8) multiply-by-two, advances the round constant
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic key_cfg_t mode_cfg(input logic [1:0] m);
    key_cfg_t c;
    c.nk = 4'd0;
    c.nr = 4'd0;
    case (m)
      MODE_128: begin c.nk = 4'd4; c.nr = 4'd10; end
      MODE_192: begin c.nk = 4'd6; c.nr = 4'd12; end
      MODE_256: begin c.nk = 4'd8; c.nr = 4'd14; end
      default:  begin c.nk = 4'd0; c.nr = 4'd0;  end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/key_expansion_seq_word_store.sv
// Schedule word store: W_DEPTH x 32 register file, parallel key load, two word taps and a 128-bit round-key tap.
module key_word_store
  import key_expansion_seq_pkg::*;
(
  input  logic               clk,
  input  logic               load_en,
  input  logic [3:0]         load_nk,
  input  logic [KEY_W-1:0]   load_key,
  input  wr_req_t            wr,
  input  logic [ADDR_W-1:0]  raddr_a,
  input  logic [ADDR_W-1:0]  raddr_b,
  output logic [WORD_W-1:0]  rdata_a_c,
  output logic [WORD_W-1:0]  rdata_b_c,
  input  logic [ROUND_W-1:0] qaddr,
  output logic [RK_W-1:0]    qdata_c
);

  logic [WORD_W-1:0] mem [W_DEPTH];

  // Contents are not reset; validity is tracked by the controller
  always_ff @(posedge clk) begin
    if (load_en) begin
      for (int j = 0; j < int'(NK_MAX); j++) begin
        if (4'(j) < load_nk) begin
          mem[j] <= load_key[KEY_W-1-WORD_W*j -: WORD_W];
        end
      end
    end else if (wr.en) begin
      mem[wr.addr] <= wr.data;
    end
  end

  // Out-of-range taps read as zero
  always_comb begin
    rdata_a_c = '0;
    rdata_b_c = '0;
    if (raddr_a < ADDR_W'(W_DEPTH)) rdata_a_c = mem[raddr_a];
    if (raddr_b < ADDR_W'(W_DEPTH)) rdata_b_c = mem[raddr_b];
  end

  always_comb begin
    qdata_c = '0;
    if (qaddr <= ROUND_W'(ROUND_MAX)) begin
      for (int k = 0; k < int'(NB); k++) begin
        qdata_c[RK_W-1-WORD_W*k -: WORD_W] = mem[{qaddr, 2'b00} + ADDR_W'(k)];
      end
    end
  end

endmodule

// File: rtl/key_expansion_seq.sv
// Iterative AES-128/192/256 key schedule: one word per clock into a store, registered round-key read port.
module key_expansion_seq
  import key_expansion_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [KEY_W-1:0]   key_in,
  output logic               busy,
  output logic               done,
  output logic               keys_ready,
  output logic               cfg_err,
  output logic [3:0]         nr_out,
  input  logic               rd_en,
  input  logic [ROUND_W-1:0] rd_round,
  output logic               rk_valid,
  output logic [RK_W-1:0]    rk_data
);

  state_e            state_q, state_d;
  logic [3:0]        nk_q, nk_d;
  logic [3:0]        nr_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        rcon_q, rcon_d;
  logic              busy_d, done_d, keys_ready_d, cfg_err_d;

  key_cfg_t          cfg;
  logic              load_en;
  wr_req_t           wr;
  logic [WORD_W-1:0] prev_c, back_c, sub_in, sub_out, temp;
  logic [RK_W-1:0]   quad_c;

  key_word_store u_store (
    .clk       (clk),
    .load_en   (load_en),
    .load_nk   (cfg.nk),
    .load_key  (key_in),
    .wr        (wr),
    .raddr_a   (i_q - ADDR_W'(1)),
    .raddr_b   (i_q - ADDR_W'(nk_q)),
    .rdata_a_c (prev_c),
    .rdata_b_c (back_c),
    .qaddr     (rd_round),
    .qdata_c   (quad_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      nk_q       <= '0;
      nr_out     <= '0;
      i_q        <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      rcon_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_ready <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      nk_q       <= nk_d;
      nr_out     <= nr_d;
      i_q        <= i_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      rcon_q     <= rcon_d;
      busy       <= busy_d;
      done       <= done_d;
      keys_ready <= keys_ready_d;
      cfg_err    <= cfg_err_d;
    end
  end

  // One shared SubWord: rotated input only on the i mod nk = 0 step
  always_comb begin
    sub_in  = (cnt_q == 3'd0) ? rot_word(prev_c) : prev_c;
    sub_out = sub_word(sub_in);
    if (cnt_q == 3'd0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (nk_q == 4'd8 && cnt_q == 3'd4) begin
      temp = sub_out;
    end else begin
      temp = prev_c;
    end
  end

  always_comb begin
    state_d      = state_q;
    nk_d         = nk_q;
    nr_d         = nr_out;
    i_d          = i_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    rcon_d       = rcon_q;
    busy_d       = busy;
    done_d       = 1'b0;
    keys_ready_d = keys_ready;
    cfg_err_d    = 1'b0;
    load_en      = 1'b0;
    wr           = '0;
    cfg          = mode_cfg(mode);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mode == MODE_ILL) begin
            cfg_err_d = 1'b1;
          end else begin
            load_en      = 1'b1;
            nk_d         = cfg.nk;
            nr_d         = cfg.nr;
            i_d          = ADDR_W'(cfg.nk);
            last_d       = {cfg.nr, 2'b00} + ADDR_W'(NB - 1);
            cnt_d        = 3'd0;
            rcon_d       = RCON_INIT;
            busy_d       = 1'b1;
            keys_ready_d = 1'b0;
            state_d      = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        wr.en   = 1'b1;
        wr.addr = i_q;
        wr.data = back_c ^ temp;
        if (cnt_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == last_q) begin
          busy_d       = 1'b0;
          done_d       = 1'b1;
          keys_ready_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          i_d   = i_q + ADDR_W'(1);
          cnt_d = ({1'b0, cnt_q} == nk_q - 4'd1) ? 3'd0 : cnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Round-key read: invalid schedule or out-of-range round answers zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_valid <= 1'b0;
      rk_data  <= '0;
    end else begin
      rk_valid <= rd_en;
      if (rd_en) begin
        rk_data <= (keys_ready && rd_round <= nr_out) ? quad_c : '0;
      end
    end
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Self-checking bench: FIPS-197 reference schedule built from GF(2^8) arithmetic, fixed vectors plus random keys.
module tb_key_expansion_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [255:0] key_in = '0;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_round = 4'd0;
  logic         busy, done, keys_ready, cfg_err, rk_valid;
  logic [3:0]   nr_out;
  logic [127:0] rk_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  sb [256];
  logic [31:0] mw [60];
  int          m_nr;

  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  key_expansion_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_ready (keys_ready),
    .cfg_err    (cfg_err),
    .nr_out     (nr_out),
    .rd_en      (rd_en),
    .rd_round   (rd_round),
    .rk_valid   (rk_valid),
    .rk_data    (rk_data)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] rcon_of(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int n = 1; n < j; n++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic model_expand(input logic [1:0] m, input logic [255:0] k);
    int nk, total;
    logic [31:0] t;
    nk    = 4 + 2 * int'(m);
    m_nr  = nk + 6;
    total = 4 * (m_nr + 1);
    for (int i = 0; i < nk; i++) mw[i] = k[255 - 32 * i -: 32];
    for (int i = nk; i < total; i++) begin
      t = mw[i - 1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      mw[i] = mw[i - nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4 * r], mw[4 * r + 1], mw[4 * r + 2], mw[4 * r + 3]};
  endfunction

  // Entered and left at 1 time unit after a rising edge
  task automatic read_rk(input int r, output logic v, output logic [127:0] d);
    rd_en = 1'b1;
    rd_round = 4'(r);
    @(posedge clk); #1;
    rd_en = 1'b0;
    v = rk_valid;
    d = rk_data;
  endtask

  task automatic run_job(input logic [1:0] m, input logic [255:0] k, input bit probe);
    int cyc, exp_lat;
    bit got;
    model_expand(m, k);
    exp_lat = 1 + 4 * (m_nr + 1) - (4 + 2 * int'(m));
    start = 1'b1; mode = m; key_in = k;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; got = 1'b0;
    check("busy_after_accept", 128'(busy), 128'(1));
    check("keys_ready_cleared", 128'(keys_ready), 128'(0));
    while (!got && cyc < 200) begin
      if (probe && cyc == 5) begin
        rd_en = 1'b1; rd_round = 4'd0; start = 1'b1; mode = 2'd0; key_in = ~k;
      end
      @(posedge clk); #1;
      cyc++;
      if (probe && cyc == 6) begin
        rd_en = 1'b0; start = 1'b0; mode = m; key_in = k;
        check("rd_expand_valid", 128'(rk_valid), 128'(1));
        check("rd_expand_data", rk_data, 128'(0));
      end
      got = done;
    end
    check("done_latency", got ? 128'(cyc) : 128'(0), 128'(exp_lat));
    check("keys_ready_set", 128'(keys_ready), 128'(1));
    check("busy_clear", 128'(busy), 128'(0));
    check("nr_out", 128'(nr_out), 128'(m_nr));
    @(posedge clk); #1;
    check("done_one_cycle", 128'(done), 128'(0));
  endtask

  task automatic verify_all();
    logic v;
    logic [127:0] d;
    for (int r = 0; r <= m_nr; r++) begin
      read_rk(r, v, d);
      check($sformatf("rk_valid_r%0d", r), 128'(v), 128'(1));
      check($sformatf("rk_data_r%0d", r), d, model_rk(r));
    end
    read_rk(m_nr + 1, v, d);
    check("rk_above_nr", d, 128'(0));
    read_rk(15, v, d);
    check("rk15_valid", 128'(v), 128'(1));
    check("rk15_data", d, 128'(0));
  endtask

  initial begin
    logic         v;
    logic [127:0] d;
    logic [1:0]   m;
    logic [255:0] k;
    int           done_seen;

    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_keys_ready", 128'(keys_ready), 128'(0));
    check("rst_cfg_err", 128'(cfg_err), 128'(0));
    check("rst_rk_valid", 128'(rk_valid), 128'(0));
    check("rst_rk_data", rk_data, 128'(0));
    check("rst_nr_out", 128'(nr_out), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // AES-128 vector with random junk in the ignored key LSBs
    k = {128'h2b7e151628aed2a6abf7158809cf4f3c, $urandom, $urandom, $urandom, $urandom};
    run_job(2'd0, k, 1'b1);
    verify_all();
    read_rk(1, v, d);
    check("aes128_round1", d, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk(10, v, d);
    check("aes128_w43", 128'(d[31:0]), 128'(32'hb6630ca6));

    // Illegal mode must not disturb the finished schedule
    start = 1'b1; mode = 2'd3;
    @(posedge clk); #1;
    start = 1'b0; mode = 2'd0;
    check("cfg_err_pulse", 128'(cfg_err), 128'(1));
    check("cfg_err_busy", 128'(busy), 128'(0));
    check("cfg_err_keys_ready", 128'(keys_ready), 128'(1));
    @(posedge clk); #1;
    check("cfg_err_clear", 128'(cfg_err), 128'(0));
    check("cfg_err_nr_out", 128'(nr_out), 128'(10));
    read_rk(1, v, d);
    check("cfg_err_round1", d, model_rk(1));

    run_job(2'd1, K192, 1'b0);
    verify_all();
    read_rk(1, v, d);
    check("aes192_w6", 128'(d[63:32]), 128'(32'hfe0c91f7));
    read_rk(12, v, d);
    check("aes192_w51", 128'(d[31:0]), 128'(32'h01002202));

    run_job(2'd2, K256, 1'b1);
    verify_all();
    read_rk(2, v, d);
    check("aes256_w8", 128'(d[127:96]), 128'(32'h9ba35411));
    read_rk(3, v, d);
    check("aes256_w12", 128'(d[127:96]), 128'(32'ha8b09c1a));
    read_rk(14, v, d);
    check("aes256_w59", 128'(d[31:0]), 128'(32'h706c631e));

    for (int n = 0; n < 6; n++) begin
      m = 2'(n % 3);
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_job(m, k, n >= 3);
      verify_all();
    end

    // Reset asserted mid-expansion with a read response in flight
    start = 1'b1; mode = 2'd0; key_in = k;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (18) begin @(posedge clk); #1; end
    rd_en = 1'b1; rd_round = 4'd0;
    @(posedge clk); #1;
    rd_en = 1'b0;
    check("pre_rst_busy", 128'(busy), 128'(1));
    check("pre_rst_rk_valid", 128'(rk_valid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_keys_ready", 128'(keys_ready), 128'(0));
    check("arst_rk_valid", 128'(rk_valid), 128'(0));
    check("arst_nr_out", 128'(nr_out), 128'(0));
    check("arst_done", 128'(done), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("no_done_after_rst", 128'(done_seen), 128'(0));
    check("idle_after_rst", 128'(busy), 128'(0));

    run_job(2'd2, K256, 1'b0);
    read_rk(14, v, d);
    check("post_rst_w59", 128'(d[31:0]), 128'(32'h706c631e));
    verify_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
